// File: rtl/score_high_tracker_if.sv
// Bundle between the score counter side and the display side of score_high_tracker.
// The master drives the live score and round control; the slave returns high score and display data.
interface score_high_tracker_if;
  logic [7:0] score_bcd;
  logic       game_active;
  logic       clear_high;
  logic [7:0] high_score;
  logic       new_record;
  logic [7:0] display_bcd;
  logic       record_blink;

  modport master (
    output score_bcd, game_active, clear_high,
    input  high_score, new_record, display_bcd, record_blink
  );

  modport slave (
    input  score_bcd, game_active, clear_high,
    output high_score, new_record, display_bcd, record_blink
  );
endinterface

// File: rtl/score_high_tracker.sv
// Round-based high score keeper with record blink for the seven-segment stage.
// Optional macro HIGH_SCORE_LIVE_EN: update the high score live during play.
module score_high_tracker #(
  parameter int BLINK_PERIOD = 25000000
) (
  input  logic                  clock,
  input  logic                  reset,
  score_high_tracker_if.slave   bus
);

  localparam int CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [7:0] BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       final_q, final_d;
  logic [7:0]       high_q, high_d;
  logic             nr_q, nr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic [7:0]       disp_q, disp_d;

  // Digits above 9 would compare larger than any legal score; they never count.
  function automatic logic digits_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  always_comb begin
    state_d = state_q;
    final_d = final_q;
    high_d  = high_q;
    nr_d    = nr_q;
    cnt_d   = '0;
    blink_d = 1'b0;
    disp_d  = disp_q;

    case (state_q)
      IDLE: begin
        if (bus.game_active) state_d = PLAYING;
      end
      PLAYING: begin
        if (!bus.game_active) begin
          state_d = COMPARE;
          final_d = bus.score_bcd;
        end
`ifdef HIGH_SCORE_LIVE_EN
        if (digits_ok(bus.score_bcd) && (bus.score_bcd > high_q)) begin
          high_d = bus.score_bcd;
          nr_d   = 1'b1;
        end
`endif
      end
      COMPARE: begin
        state_d = RESULT;
        if (digits_ok(final_q) && (final_q > high_q)) begin
          high_d = final_q;
          nr_d   = 1'b1;
        end
      end
      RESULT: begin
        if (bus.game_active) begin
          state_d = PLAYING;
          nr_d    = 1'b0;
        end else if (nr_q) begin
          if (cnt_q == CNT_LAST) begin
            blink_d = ~blink_q;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            blink_d = blink_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear beats any same-edge update and also stops a running blink.
    if (bus.clear_high) begin
      high_d  = 8'h00;
      nr_d    = 1'b0;
      cnt_d   = '0;
      blink_d = 1'b0;
    end

    // Display follows next-state values so the blank phase lines up with record_blink.
    case (state_d)
      IDLE:             disp_d = high_d;
      PLAYING, COMPARE: disp_d = bus.score_bcd;
      RESULT:           disp_d = (nr_d && blink_d) ? BLANK : final_d;
      default:          disp_d = high_d;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      final_q <= 8'h00;
      high_q  <= 8'h00;
      nr_q    <= 1'b0;
      cnt_q   <= '0;
      blink_q <= 1'b0;
      disp_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      final_q <= final_d;
      high_q  <= high_d;
      nr_q    <= nr_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.high_score   = high_q;
  assign bus.new_record   = nr_q;
  assign bus.display_bcd  = disp_q;
  assign bus.record_blink = blink_q;

endmodule

// File: tb/tb_score_high_tracker.sv
// Bench for score_high_tracker: directed rounds followed by random play against a round-level model.
module tb_score_high_tracker;

  localparam int BP = 4;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  score_high_tracker_if bus_if ();

  score_high_tracker #(.BLINK_PERIOD(BP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Round-level reference: phase of the round, stored high score, and how long a record has been on show.
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_CMP = 2, PH_RES = 3;
  int         m_phase;
  logic [7:0] m_high, m_final, m_disp;
  logic       m_nr, m_blink;
  int         m_shown;

  function automatic logic legal(input logic [7:0] v);
    return (v[7:4] < 4'd10) && (v[3:0] < 4'd10);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_high = 8'h00; m_final = 8'h00; m_disp = 8'h00;
    m_nr = 1'b0; m_blink = 1'b0; m_shown = 0;
  endtask

  task automatic model_edge(input logic ga, input logic [7:0] sc, input logic clr);
    int   ph;
    logic nr_before;
    ph = m_phase;
    nr_before = m_nr;
    if (ph == PH_CMP && legal(m_final) && m_final > m_high) begin
      m_high = m_final; m_nr = 1'b1;
    end
`ifdef HIGH_SCORE_LIVE_EN
    if (ph == PH_PLAY && legal(sc) && sc > m_high) begin
      m_high = sc; m_nr = 1'b1;
    end
`endif
    if (ph == PH_RES && ga) m_nr = 1'b0;
    if (clr) begin m_high = 8'h00; m_nr = 1'b0; end
    if (ph == PH_RES && nr_before && !ga && !clr) m_shown++;
    else m_shown = 0;
    case (ph)
      PH_IDLE: if (ga) m_phase = PH_PLAY;
      PH_PLAY: if (!ga) begin m_phase = PH_CMP; m_final = sc; end
      PH_CMP:  m_phase = PH_RES;
      default: if (ga) m_phase = PH_PLAY;
    endcase
    m_blink = ((m_shown / BP) % 2) == 1;
    case (m_phase)
      PH_IDLE: m_disp = m_high;
      PH_RES:  m_disp = (m_nr && m_blink) ? 8'hFF : m_final;
      default: m_disp = sc;
    endcase
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".high"},  bus_if.high_score, m_high);
    chk({tag, ".nr"},    {7'd0, bus_if.new_record}, {7'd0, m_nr});
    chk({tag, ".disp"},  bus_if.display_bcd, m_disp);
    chk({tag, ".blink"}, {7'd0, bus_if.record_blink}, {7'd0, m_blink});
  endtask

  task automatic step(input string tag, input logic ga, input logic [7:0] sc, input logic clr);
    bus_if.game_active = ga;
    bus_if.score_bcd   = sc;
    bus_if.clear_high  = clr;
    @(posedge clock);
    model_edge(ga, sc, clr);
    #1;
    check_model(tag);
  endtask

  // Plays a round from the current phase: score ramps up to final_v, then game_active drops.
  task automatic play_round(input string tag, input int final_v);
    for (int i = 0; i <= final_v; i++) step(tag, 1'b1, to_bcd(i), 1'b0);
    step(tag, 1'b0, to_bcd(final_v), 1'b0);
    step(tag, 1'b0, to_bcd(final_v), 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk({tag, ".high0"},  bus_if.high_score, 8'h00);
    chk({tag, ".nr0"},    {7'd0, bus_if.new_record}, 8'h00);
    chk({tag, ".disp0"},  bus_if.display_bcd, 8'h00);
    chk({tag, ".blink0"}, {7'd0, bus_if.record_blink}, 8'h00);
    #2 reset = 1'b1;
  endtask

  initial begin
    logic       ga;
    logic [7:0] sc;
    logic       clr;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b0;
    bus_if.game_active = 1'b0;
    bus_if.score_bcd   = 8'h00;
    bus_if.clear_high  = 1'b0;
    model_reset();
    #2;
    chk("por.high", bus_if.high_score, 8'h00);
    chk("por.disp", bus_if.display_bcd, 8'h00);
    #5 reset = 1'b1;

    step("idle", 1'b0, 8'h55, 1'b0);
    chk("idle.disp_high", bus_if.display_bcd, 8'h00);

    // New record at 37, then the blink pattern.
    play_round("rec37", 37);
    chk("rec37.high", bus_if.high_score, 8'h37);
    chk("rec37.nr", {7'd0, bus_if.new_record}, 8'h01);
    chk("rec37.disp", bus_if.display_bcd, 8'h37);
    for (int i = 0; i < 3; i++) step("blink", 1'b0, 8'h00, 1'b0);
    chk("blink.still_on", bus_if.display_bcd, 8'h37);
    step("blink", 1'b0, 8'h00, 1'b0);
    chk("blink.blank", bus_if.display_bcd, 8'hFF);
    chk("blink.phase", {7'd0, bus_if.record_blink}, 8'h01);
    for (int i = 0; i < 4; i++) step("blink", 1'b0, 8'h00, 1'b0);
    chk("blink.back", bus_if.display_bcd, 8'h37);

    // Lower, then equal final scores leave the record alone.
    play_round("low25", 25);
    for (int i = 0; i < 6; i++) step("low25", 1'b0, 8'h00, 1'b0);
    chk("low25.high", bus_if.high_score, 8'h37);
    chk("low25.disp", bus_if.display_bcd, 8'h25);
    play_round("eq37", 37);
    chk("eq37.nr", {7'd0, bus_if.new_record}, 8'h00);

    // Clear pulsed during COMPARE wins over the better score.
    for (int i = 0; i <= 50; i += 5) step("clr50", 1'b1, to_bcd(i), 1'b0);
    step("clr50", 1'b0, 8'h50, 1'b0);
    step("clr50", 1'b0, 8'h50, 1'b1);
    for (int i = 0; i < 5; i++) step("clr50", 1'b0, 8'h00, 1'b0);
    chk("clr50.high", bus_if.high_score, 8'h00);
    chk("clr50.disp", bus_if.display_bcd, 8'h50);

    // Starting the next round cancels the record display.
    play_round("rec42", 42);
    for (int i = 0; i < 5; i++) step("rec42", 1'b0, 8'h00, 1'b0);
    step("next", 1'b1, 8'h13, 1'b0);
    chk("next.nr", {7'd0, bus_if.new_record}, 8'h00);
    chk("next.disp", bus_if.display_bcd, 8'h13);
    step("next", 1'b1, 8'h14, 1'b0);

    // Invalid digits never record; one-cycle rounds are still rounds.
    step("bad", 1'b0, 8'h5A, 1'b0);
    step("bad", 1'b0, 8'h5A, 1'b0);
    chk("bad.high", bus_if.high_score, 8'h42);
    step("short", 1'b1, 8'h99, 1'b0);
    step("short", 1'b0, 8'h99, 1'b0);
    step("short", 1'b0, 8'h99, 1'b0);
    chk("short.high", bus_if.high_score, 8'h99);

    // Reset lands in the middle of a blink.
    for (int i = 0; i < 5; i++) step("preRst", 1'b0, 8'h00, 1'b0);
    async_reset("midrst");

`ifdef HIGH_SCORE_LIVE_EN
    play_round("live10", 10);
    step("live", 1'b1, 8'h09, 1'b0);
    step("live", 1'b1, 8'h09, 1'b0);
    step("live", 1'b1, 8'h10, 1'b0);
    chk("live.at10", bus_if.high_score, 8'h10);
    step("live", 1'b1, 8'h11, 1'b0);
    chk("live.at11", bus_if.high_score, 8'h11);
    chk("live.nr", {7'd0, bus_if.new_record}, 8'h01);
    step("live", 1'b0, 8'h11, 1'b0);
    step("live", 1'b0, 8'h11, 1'b0);
`endif

    // Random play.
    ga = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) ga = ~ga;
      if ($urandom_range(0, 4) == 0) sc = 8'($urandom);
      else sc = to_bcd(int'($urandom_range(0, 99)));
      clr = ($urandom_range(0, 39) == 0);
      step("rand", ga, sc, clr);
      if ($urandom_range(0, 599) == 0) async_reset("randrst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
